// File: rtl/reg_stack_dump_if.sv
// Register-stack dump bus: start/range request, stack read port, streamed beat channel, status.
// master = dump engine side, slave = requester / stack / consumer side.
interface reg_stack_dump_if #(
    parameter int WORD_WIDTH = 16,
    parameter int NIB_WIDTH  = 4
);
    logic                  start;
    logic [NIB_WIDTH-1:0]  first;
    logic [NIB_WIDTH-1:0]  last;
    logic [NIB_WIDTH-1:0]  regnum;
    logic [WORD_WIDTH-1:0] reg_val;
    logic [WORD_WIDTH-1:0] out_data;
    logic [NIB_WIDTH-1:0]  out_index;
    logic                  out_last;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, first, last, reg_val, out_ready,
        output regnum, out_data, out_index, out_last, out_valid, busy, done
    );

    modport slave (
        output start, first, last, reg_val, out_ready,
        input  regnum, out_data, out_index, out_last, out_valid, busy, done
    );
endinterface

// File: rtl/reg_stack_dump.sv
// Walks a register range over the stack read port and streams each word out; optional XOR trailer beat (REG_STACK_DUMP_CHECKSUM_EN).
// Latency: first out_valid 2 clocks after start; one word per 2 clocks (READ + PRESENT) with out_ready high.
// Backpressure: a presented beat is held stable while out_ready is low; stack is re-read only for the next index.
module reg_stack_dump #(
    parameter int          WORD_WIDTH     = 16,
    parameter int          NIB_WIDTH      = 4,
    parameter int unsigned REG_STACK_SIZE = 16
) (
    input  logic           clk,
    input  logic           reset,
    reg_stack_dump_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, PRESENT, CSUM} state_t;

    state_t                state_q, state_nxt;
    logic [NIB_WIDTH-1:0]  regnum_q, regnum_nxt;
    logic [NIB_WIDTH-1:0]  last_q, last_nxt;
    logic [WORD_WIDTH-1:0] out_data_q, out_data_nxt;
    logic [NIB_WIDTH-1:0]  out_index_q, out_index_nxt;
    logic                  out_last_q, out_last_nxt;
    logic                  out_valid_q, out_valid_nxt;
    logic                  busy_q, busy_nxt;
    logic                  done_q, done_nxt;
`ifdef REG_STACK_DUMP_CHECKSUM_EN
    logic [WORD_WIDTH-1:0] csum_q, csum_nxt;
`endif

    function automatic logic [NIB_WIDTH-1:0] reduce(input logic [NIB_WIDTH-1:0] x);
        return NIB_WIDTH'(32'(x) % REG_STACK_SIZE);
    endfunction

    function automatic logic [NIB_WIDTH-1:0] incr(input logic [NIB_WIDTH-1:0] x);
        return (x == NIB_WIDTH'(REG_STACK_SIZE - 1)) ? '0 : x + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            regnum_q    <= '0;
            last_q      <= '0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef REG_STACK_DUMP_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_nxt;
            regnum_q    <= regnum_nxt;
            last_q      <= last_nxt;
            out_data_q  <= out_data_nxt;
            out_index_q <= out_index_nxt;
            out_last_q  <= out_last_nxt;
            out_valid_q <= out_valid_nxt;
            busy_q      <= busy_nxt;
            done_q      <= done_nxt;
`ifdef REG_STACK_DUMP_CHECKSUM_EN
            csum_q      <= csum_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt     = state_q;
        regnum_nxt    = regnum_q;
        last_nxt      = last_q;
        out_data_nxt  = out_data_q;
        out_index_nxt = out_index_q;
        out_last_nxt  = out_last_q;
        out_valid_nxt = out_valid_q;
        busy_nxt      = busy_q;
        done_nxt      = 1'b0;
`ifdef REG_STACK_DUMP_CHECKSUM_EN
        csum_nxt      = csum_q;
`endif
        case (state_q)
            IDLE: begin
                // The done cycle itself never launches a new dump.
                if (bus.start && !done_q) begin
                    regnum_nxt = reduce(bus.first);
                    last_nxt   = reduce(bus.last);
                    busy_nxt   = 1'b1;
                    state_nxt  = READ;
`ifdef REG_STACK_DUMP_CHECKSUM_EN
                    csum_nxt   = '0;
`endif
                end
            end
            READ: begin
                out_data_nxt  = bus.reg_val;
                out_index_nxt = regnum_q;
                out_valid_nxt = 1'b1;
`ifdef REG_STACK_DUMP_CHECKSUM_EN
                out_last_nxt  = 1'b0;
`else
                out_last_nxt  = (regnum_q == last_q);
`endif
                state_nxt     = PRESENT;
            end
            PRESENT: begin
                if (bus.out_ready) begin
                    out_valid_nxt = 1'b0;
`ifdef REG_STACK_DUMP_CHECKSUM_EN
                    csum_nxt = csum_q ^ out_data_q;
`endif
                    if (out_index_q == last_q) begin
`ifdef REG_STACK_DUMP_CHECKSUM_EN
                        out_data_nxt  = csum_q ^ out_data_q;
                        out_index_nxt = last_q;
                        out_last_nxt  = 1'b1;
                        out_valid_nxt = 1'b1;
                        state_nxt     = CSUM;
`else
                        done_nxt      = 1'b1;
                        busy_nxt      = 1'b0;
                        state_nxt     = IDLE;
`endif
                    end else begin
                        regnum_nxt = incr(regnum_q);
                        state_nxt  = READ;
                    end
                end
            end
`ifdef REG_STACK_DUMP_CHECKSUM_EN
            CSUM: begin
                if (bus.out_ready) begin
                    out_valid_nxt = 1'b0;
                    done_nxt      = 1'b1;
                    busy_nxt      = 1'b0;
                    state_nxt     = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.regnum    = regnum_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_index = out_index_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_reg_stack_dump.sv
// Scoreboard bench for reg_stack_dump: directed dumps push expected beats, a negedge monitor pops and compares.
module tb_reg_stack_dump;
    localparam int W = 16;
    localparam int N = 4;
    localparam int S = 16;
`ifdef REG_STACK_DUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    typedef struct packed {
        logic [W-1:0] d;
        logic [N-1:0] i;
        logic         l;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_stack_dump_if #(.WORD_WIDTH(W), .NIB_WIDTH(N)) bus();
    reg_stack_dump #(.WORD_WIDTH(W), .NIB_WIDTH(N), .REG_STACK_SIZE(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [W-1:0] regs [S];
    assign bus.reg_val = regs[bus.regnum];

    beat_t        exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           done_cnt = 0;
    int           beats_seen = 0;
    logic [W-1:0] last_data;
    logic [N-1:0] last_idx;
    logic         stalled = 1'b0;
    beat_t        held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        beat_t cur, e;
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (bus.done) done_cnt++;
            if (bus.out_valid) begin
                cur.d = bus.out_data;
                cur.i = bus.out_index;
                cur.l = bus.out_last;
                if (stalled) check("stall_hold", 32'(cur), 32'(held));
                if (bus.out_ready) begin
                    check("beat_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("beat_data", 32'(cur.d), 32'(e.d));
                        check("beat_index", 32'(cur.i), 32'(e.i));
                        check("beat_last", 32'(cur.l), 32'(e.l));
                    end
                    beats_seen++;
                    last_data = cur.d;
                    last_idx  = cur.i;
                    stalled   = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = cur;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic push_range(input int f, input int l);
        int    n;
        beat_t b;
        logic [W-1:0] x;
        n = (((l - f) % S) + S) % S + 1;
        x = '0;
        for (int k = 0; k < n; k++) begin
            b.i = N'((f + k) % S);
            b.d = regs[b.i];
            b.l = (k == n - 1) && (CS == 0);
            x   = x ^ b.d;
            exp_q.push_back(b);
        end
        if (CS != 0) begin
            b.d = x;
            b.i = N'(l);
            b.l = 1'b1;
            exp_q.push_back(b);
        end
    endtask

    // Drives start for the accept edge; returns at accept edge + 1.
    task automatic start_dump(input int f, input int l);
        bus.first = N'(f);
        bus.last  = N'(l);
        bus.start = 1'b1;
        push_range(f, l);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!bus.done && cycles < budget) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("done_seen", 32'(bus.done), 1);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_valid"}, 32'(bus.out_valid), 0);
        check({name, "_last"},  32'(bus.out_last), 0);
        check({name, "_data"},  32'(bus.out_data), 0);
        check({name, "_index"}, 32'(bus.out_index), 0);
        check({name, "_regnum"},32'(bus.regnum), 0);
        check({name, "_busy"},  32'(bus.busy), 0);
        check({name, "_done"},  32'(bus.done), 0);
    endtask

    initial begin
        int cyc, more, d0, b0, guard;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.first = '0;
        bus.last  = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < S; i++) regs[i] = W'(i * 3);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_idle_outputs("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Full range 0..15: latency, done timing and pulse width
        d0 = done_cnt;
        start_dump(0, 15);
        check("lat_valid_1clk", 32'(bus.out_valid), 0);
        check("busy_after_start", 32'(bus.busy), 1);
        @(posedge clk); #1;
        check("lat_valid_2clk", 32'(bus.out_valid), 1);
        wait_done(200, more);
        check("start_to_done", 32'(2 + more), 32'(33 + CS));
        check("busy_cleared", 32'(bus.busy), 0);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(bus.done), 0);
        check("done_count_t1", 32'(done_cnt - d0), 1);
        check("queue_empty_t1", 32'(exp_q.size()), 0);

        // Wrapping range and single-word range
        b0 = beats_seen;
        start_dump(14, 1);
        wait_done(200, more);
        @(posedge clk); #1;
        check("wrap_beats", 32'(beats_seen - b0), 32'(4 + CS));
        b0 = beats_seen;
        start_dump(7, 7);
        wait_done(200, more);
        @(posedge clk); #1;
        check("single_beats", 32'(beats_seen - b0), 32'(1 + CS));
        check("single_last_idx", 32'(last_idx), 7);
        check("queue_empty_t2", 32'(exp_q.size()), 0);

        // Backpressure on idx 2 while the stack word changes underneath
        regs[2] = 16'h1234;
        b0 = beats_seen;
        start_dump(0, 4);
        guard = 0;
        while (!(bus.out_valid && bus.out_index == 2) && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("reach_idx2", 32'(guard < 50), 1);
        bus.out_ready = 1'b0;
        regs[2] = 16'hBEEF;
        repeat (5) @(posedge clk);
        #1;
        check("stall_valid", 32'(bus.out_valid), 1);
        check("stall_data", 32'(bus.out_data), 32'h1234);
        bus.out_ready = 1'b1;
        wait_done(200, more);
        @(posedge clk); #1;
        check("bp_beats", 32'(beats_seen - b0), 32'(5 + CS));
        check("queue_empty_t3", 32'(exp_q.size()), 0);
        regs[2] = 16'h0006;

        // Reset mid-dump after beat idx 3
        d0 = done_cnt;
        b0 = beats_seen;
        start_dump(0, 15);
        guard = 0;
        while ((beats_seen - b0) < 4 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("reach_beat3", 32'(guard < 50), 1);
        #3 reset = 1'b1;
        #1 check_idle_outputs("midreset");
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("no_done_on_reset", 32'(done_cnt - d0), 0);
        b0 = beats_seen;
        start_dump(9, 11);
        wait_done(200, more);
        @(posedge clk); #1;
        check("post_reset_beats", 32'(beats_seen - b0), 32'(3 + CS));
        check("queue_empty_t4", 32'(exp_q.size()), 0);

        // start while busy is ignored
        b0 = beats_seen;
        start_dump(0, 5);
        repeat (3) @(posedge clk);
        #1;
        bus.first = 4'd5;
        bus.last  = 4'd5;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(200, more);
        @(posedge clk); #1;
        check("busy_start_beats", 32'(beats_seen - b0), 32'(6 + CS));
        repeat (4) @(posedge clk);
        #1;
        check("busy_start_no_relaunch", 32'(bus.busy), 0);
        check("queue_empty_t5", 32'(exp_q.size()), 0);

        // Checksum trailer on a one-hot pattern
        regs[0] = 16'h0001; regs[1] = 16'h0002; regs[2] = 16'h0004; regs[3] = 16'h0008;
        b0 = beats_seen;
        start_dump(0, 3);
        wait_done(200, more);
        @(posedge clk); #1;
        check("csum_beats", 32'(beats_seen - b0), 32'(4 + CS));
        check("csum_last_data", 32'(last_data), (CS != 0) ? 32'h000F : 32'h0008);
        check("csum_last_idx", 32'(last_idx), 3);
        check("queue_empty_t6", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
